detect_face: RTL and testbench

Sliding-window face detector for captured camera frames. It latches one grayscale frame and scans a fixed-size window over several integer-decimated pyramid levels. Each window is scored with a single two-rectangle Haar-like feature: top half minus bottom half. Every window whose score exceeds a threshold is reported as a coordinate pulse, followed by a completion pulse. It sits between the frame-capture path and the host/display result logic.

---
 rtl/detect_face.sv | 227 ++++++++++++++++++++++
 tb/tb_detect_face.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_face.sv
// Sliding-window face detector.
// Captures one grayscale frame, then walks a WIN x WIN window over several
// integer-decimated pyramid levels, one sampled pixel per cycle. Each window
// is scored with a single two-rectangle Haar-like feature: the top half of
// the window minus the bottom half. A window whose score exceeds THRESH
// produces a one-cycle coordinate pulse. A one-cycle done pulse follows the
// last window.
module detect_face #(
    parameter int                 LAPTOP_WIDTH  = 32,
    parameter int                 LAPTOP_HEIGHT = 24,
    parameter int                 WIN           = 8,
    parameter int                 NUM_LEVELS    = 3,
    parameter logic signed [31:0] THRESH        = 32'sd1000
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] laptop_img,
    input  logic                                          laptop_img_rdy,
    output logic [1:0][31:0]                              face_coords,
    output logic                                          face_coords_ready,
    output logic [3:0]                                    pyramid_number,
    output logic                                          vj_pipeline_done
);

    // Window-position counters are kept wide enough for any practical frame.
    localparam int CW  = 16;
    localparam int IW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int RW  = (LAPTOP_HEIGHT > 1) ? $clog2(LAPTOP_HEIGHT) : 1;
    localparam int CLW = (LAPTOP_WIDTH > 1) ? $clog2(LAPTOP_WIDTH) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(WIN - 1);
    localparam logic [IW-1:0] IDX_HALF = IW'(WIN / 2);

    // FINISH is the single cycle between the last window and the done pulse.
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    // A level contributes windows only if the decimated frame holds one window.
    function automatic logic level_ok(input int q);
        return ((LAPTOP_WIDTH / (q + 1)) >= WIN) && ((LAPTOP_HEIGHT / (q + 1)) >= WIN);
    endfunction

    state_t state_q, state_d;

    logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] frame_buf;

    logic [3:0]          level_q;
    logic [CW-1:0]       row_q, col_q;
    logic [IW-1:0]       pi_q, pj_q;
    logic signed [31:0]  acc_q;

    logic [CW-1:0]       cur_s, c_max, r_max;
    logic                nxt_found, first_found;
    logic [3:0]          nxt_lvl, first_lvl;

    logic [RW-1:0]       row_idx;
    logic [CLW-1:0]      col_idx;
    logic [7:0]          pix;
    logic signed [31:0]  term, d_total;

    logic                win_last, col_last, row_last, scan_end, hit, start;

    logic                ready_d, done_d;
    logic [1:0][31:0]    coords_d;
    logic [3:0]          pyr_d;

    // Geometry of the level currently being scanned: scale and last window origin.
    // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cur_s = '0;
        c_max = '0;
        r_max = '0;
        for (int q = 0; q < NUM_LEVELS; q++) begin
            if (level_q == 4'(q)) begin
                cur_s = CW'(q + 1);
                c_max = CW'(LAPTOP_WIDTH / (q + 1) - WIN);
                r_max = CW'(LAPTOP_HEIGHT / (q + 1) - WIN);
            end
        end
    end

    // First usable level, and the next usable level after the current one.
    always_comb begin
        first_found = 1'b0;
        first_lvl   = '0;
        nxt_found   = 1'b0;
        nxt_lvl     = '0;
        for (int q = NUM_LEVELS - 1; q >= 0; q--) begin
            if (level_ok(q)) begin
                first_found = 1'b1;
                first_lvl   = 4'(q);
                if (4'(q) > level_q) begin
                    nxt_found = 1'b1;
                    nxt_lvl   = 4'(q);
                end
            end
        end
    end

    // Fetch the sampled pixel and fold it into the running window score.
    always_comb begin
        row_idx  = RW'((row_q + CW'(pi_q)) * cur_s);
        col_idx  = CLW'((col_q + CW'(pj_q)) * cur_s);
        pix      = frame_buf[row_idx][col_idx];
        term     = (pi_q < IDX_HALF) ? $signed({24'd0, pix}) : -$signed({24'd0, pix});
        d_total  = acc_q + term;
        win_last = (pi_q == IDX_LAST) && (pj_q == IDX_LAST);
        col_last = (col_q == c_max);
        row_last = (row_q == r_max);
        scan_end = win_last && col_last && row_last && !nxt_found;
        hit      = (state_q == SCAN) && win_last && (d_total > THRESH);
        // A strobe seen while the previous done pulse is still high is ignored.
        start    = (state_q == IDLE) && laptop_img_rdy && !vj_pipeline_done;
    end

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = first_found ? SCAN : FINISH;
            SCAN:    if (scan_end) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; coordinates hold between detections.
    always_comb begin
        ready_d  = hit;
        done_d   = (state_q == FINISH);
        coords_d = face_coords;
        pyr_d    = pyramid_number;
        if (hit) begin
            coords_d[0] = 32'(row_q * cur_s);
            coords_d[1] = 32'(col_q * cur_s);
            pyr_d       = level_q;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            face_coords       <= '0;
            face_coords_ready <= 1'b0;
            pyramid_number    <= '0;
            vj_pipeline_done  <= 1'b0;
        end else begin
            face_coords       <= coords_d;
            face_coords_ready <= ready_d;
            pyramid_number    <= pyr_d;
            vj_pipeline_done  <= done_d;
        end
    end

    // Frame buffer: loaded on a start so the input frame may change during the scan.
    // NOTE: the frame buffer is storage, not control state, so it has no reset.
    always_ff @(posedge clock) begin
        if (start) begin
            frame_buf <= laptop_img;
        end
    end

    // Scan counters and score accumulator: j fastest, then i, column, row, level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pi_q    <= '0;
            pj_q    <= '0;
            acc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        level_q <= first_lvl;
                        row_q   <= '0;
                        col_q   <= '0;
                        pi_q    <= '0;
                        pj_q    <= '0;
                        acc_q   <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= win_last ? 32'sd0 : d_total;
                    if (pj_q != IDX_LAST) begin
                        pj_q <= pj_q + IW'(1);
                    end else begin
                        pj_q <= '0;
                        if (pi_q != IDX_LAST) begin
                            pi_q <= pi_q + IW'(1);
                        end else begin
                            pi_q <= '0;
                            if (!col_last) begin
                                col_q <= col_q + CW'(1);
                            end else begin
                                col_q <= '0;
                                if (!row_last) begin
                                    row_q <= row_q + CW'(1);
                                end else begin
                                    row_q <= '0;
                                    if (nxt_found) level_q <= nxt_lvl;
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_face.sv
// Self-checking bench for detect_face. A reference model of the window scan
// pushes every expected detection (edge, level, row, col) into a scoreboard
// when a frame is started; a monitor pops and compares on each pulse.
module tb_detect_face;

    localparam int W  = 32;
    localparam int H  = 24;
    localparam int WN = 8;
    localparam int NL = 3;
    localparam int TH = 1000;

    typedef struct {
        longint at_edge;
        int     p;
        int     row;
        int     col;
    } hit_t;

    logic clock;
    logic reset;

    // Default-parameter instance.
    logic [H-1:0][W-1:0][7:0] img;
    logic                     rdy;
    logic [1:0][31:0]         coords;
    logic                     ready;
    logic [3:0]               pyr;
    logic                     done;

    // Instance whose every level is too small for a window.
    logic [6:0][6:0][7:0]     img_s;
    logic                     rdy_s;
    logic [1:0][31:0]         coords_s;
    logic                     ready_s;
    logic [3:0]               pyr_s;
    logic                     done_s;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    hit_t   sb[$];
    int     hits = 0;
    int     extra = 0;
    int     done_cnt = 0;
    longint done_edge = -1;

    int     s_done_cnt = 0;
    int     s_extra = 0;
    longint s_done_edges[$];

    detect_face dut (
        .clock             (clock),
        .reset             (reset),
        .laptop_img        (img),
        .laptop_img_rdy    (rdy),
        .face_coords       (coords),
        .face_coords_ready (ready),
        .pyramid_number    (pyr),
        .vj_pipeline_done  (done)
    );

    detect_face #(
        .LAPTOP_WIDTH  (7),
        .LAPTOP_HEIGHT (7),
        .WIN           (8),
        .NUM_LEVELS    (3),
        .THRESH        (32'sd1000)
    ) dut_small (
        .clock             (clock),
        .reset             (reset),
        .laptop_img        (img_s),
        .laptop_img_rdy    (rdy_s),
        .face_coords       (coords_s),
        .face_coords_ready (ready_s),
        .pyramid_number    (pyr_s),
        .vj_pipeline_done  (done_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (ready) begin
            if (sb.size() > 0) begin
                hit_t e;
                e = sb.pop_front();
                hits++;
                check("hit_edge", cyc, e.at_edge);
                check("hit_row", longint'(coords[0]), longint'(e.row));
                check("hit_col", longint'(coords[1]), longint'(e.col));
                check("hit_level", longint'(pyr), longint'(e.p));
            end else begin
                extra++;
            end
        end
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
        if (ready_s) s_extra++;
        if (done_s) begin
            s_done_cnt++;
            s_done_edges.push_back(cyc);
        end
    end

    // Reference scan: pushes expected detections, returns the window count.
    task automatic model_frame(input logic [H-1:0][W-1:0][7:0] f, input longint t0, output int k);
        k = 0;
        for (int p = 0; p < NL; p++) begin
            int s, wp, hp;
            s  = p + 1;
            wp = W / s;
            hp = H / s;
            if (wp < WN || hp < WN) continue;
            for (int r = 0; r <= hp - WN; r++) begin
                for (int c = 0; c <= wp - WN; c++) begin
                    int d;
                    d = 0;
                    for (int i = 0; i < WN; i++) begin
                        for (int j = 0; j < WN; j++) begin
                            if (i < WN / 2) d += int'(f[(r + i) * s][(c + j) * s]);
                            else            d -= int'(f[(r + i) * s][(c + j) * s]);
                        end
                    end
                    if (d > TH) sb.push_back('{t0 + longint'((k + 1) * WN * WN), p, r * s, c * s});
                    k++;
                end
            end
        end
    endtask

    task automatic start_frame(output longint t0, output int k);
        @(posedge clock);
        #1;
        t0 = cyc + 1;
        model_frame(img, t0, k);
        rdy = 1'b1;
        @(posedge clock);
        #1;
        rdy = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        for (int n = 0; n < budget && done_cnt == prev; n++) @(negedge clock);
        check("done_seen", done_cnt, prev + 1);
    endtask

    task automatic fill_rows(input int lo, input int hi);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (r >= lo && r <= hi) ? 8'hFF : 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint t0;
        int     k;
        int     d0;
        longint e1, e2;

        reset = 1'b0;
        rdy   = 1'b0;
        rdy_s = 1'b0;
        img   = '0;
        img_s = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_row", longint'(coords[0]), 0);
        check("rst_col", longint'(coords[1]), 0);
        check("rst_level", longint'(pyr), 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // K = 0 instance, strobe held high for four edges: the edge while done
        // is high is ignored, the one after it starts a second scan.
        #1;
        t0 = cyc + 1;
        rdy_s = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        rdy_s = 1'b0;
        repeat (5) @(posedge clock);
        e1 = (s_done_edges.size() > 0) ? s_done_edges[0] : -1;
        e2 = (s_done_edges.size() > 1) ? s_done_edges[1] : -1;
        check("small_done_count", s_done_cnt, 2);
        check("small_done_first", e1, t0 + 1);
        check("small_done_second", e2, t0 + 4);
        check("small_no_hits", s_extra, 0);

        // Rows 0..3 bright; a second strobe with a different frame mid-scan.
        fill_rows(0, 3);
        hits = 0;
        extra = 0;
        d0 = done_cnt;
        start_frame(t0, k);
        repeat (1000) @(posedge clock);
        #1;
        img = '1;
        rdy = 1'b1;
        @(posedge clock);
        #1;
        rdy = 1'b0;
        wait_done(d0, 31000);
        check("top_done_edge", done_edge, t0 + 473 * 64 + 1);
        check("top_hit_count", hits, 121);
        check("top_extra", extra, 0);
        check("top_sb_empty", sb.size(), 0);
        check("top_hold_row", longint'(coords[0]), 0);
        check("top_hold_col", longint'(coords[1]), 6);
        check("top_hold_level", longint'(pyr), 2);
        repeat (4) @(posedge clock);
        check("top_single_done", done_cnt, d0 + 1);

        // Reset mid-scan aborts with no done pulse.
        fill_rows(0, 3);
        hits = 0;
        extra = 0;
        start_frame(t0, k);
        repeat (199) @(posedge clock);
        #1;
        check("pre_abort_col", longint'(coords[1]), 2);
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 0);
        check("abort_done", done, 0);
        check("abort_col", longint'(coords[1]), 0);
        check("abort_level", longint'(pyr), 0);
        sb.delete();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        d0 = done_cnt;
        extra = 0;
        repeat (100) @(posedge clock);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_hits", extra, 0);

        // Rows 20..23 bright: every score negative, full-length scan.
        fill_rows(20, 23);
        hits = 0;
        extra = 0;
        d0 = done_cnt;
        start_frame(t0, k);
        wait_done(d0, 31000);
        check("bot_done_edge", done_edge, t0 + 30273);
        check("bot_hit_count", hits, 0);
        check("bot_extra", extra, 0);
        check("bot_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
